// File: rtl/color_mix_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : color_mix_pipe                                             |
// | Description : 3-stage RGB colour-mix pipeline (colour, tinted mono,      |
// |               inverted, black) with frame-synchronous mode switching.    |
// |               Define COLOR_MIX_FADE_EN to enable the per-frame           |
// |               brightness fade-out / fade-in around every mode change.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module color_mix_pipe #(
  parameter int DW        = 8,
  parameter int FADE_LOG2 = 3
) (
  input  logic          clk_vid,
  input  logic          reset_n,
  input  logic          ce_pix,
  input  logic [2:0]    mix,
  input  logic [DW-1:0] R_in,
  input  logic [DW-1:0] G_in,
  input  logic [DW-1:0] B_in,
  input  logic          HSync_in,
  input  logic          VSync_in,
  input  logic          HBlank_in,
  input  logic          VBlank_in,
  output logic [DW-1:0] R_out,
  output logic [DW-1:0] G_out,
  output logic [DW-1:0] B_out,
  output logic          HSync_out,
  output logic          VSync_out,
  output logic          HBlank_out,
  output logic          VBlank_out,
  output logic [2:0]    mode_active,
  output logic          busy
);

  // Elaboration-time guard on the supported parameter range
  if (DW < 4 || DW > 12 || FADE_LOG2 < 0 || FADE_LOG2 > 8) begin : g_param_check
    $error("color_mix_pipe: DW must be 4..12 and FADE_LOG2 0..8");
  end

  localparam logic [2:0]    MODE_GREEN = 3'd2;
  localparam logic [2:0]    MODE_AMBER = 3'd3;
  localparam logic [2:0]    MODE_CYAN  = 3'd4;
  localparam logic [2:0]    MODE_GRAY  = 3'd5;
  localparam logic [2:0]    MODE_INV   = 3'd6;
  localparam logic [DW+7:0] K_R        = (DW+8)'(54);
  localparam logic [DW+7:0] K_G        = (DW+8)'(183);
  localparam logic [DW+7:0] K_B        = (DW+8)'(18);

  // ---------------------------------------------------------------- frame tick
  logic vb_prev;
  logic frame_tick;

  // Remember VBlank as seen on the last pixel enable, for rising-edge detection
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n)    vb_prev <= 1'b0;
    else if (ce_pix) vb_prev <= VBlank_in;
  end

  assign frame_tick = ce_pix & VBlank_in & ~vb_prev;

  // ---------------------------------------------------------------- stage 1
  logic [DW+7:0] px;
  logic [DW-1:0] luma;
  logic [DW-1:0] s1_r, s1_g, s1_b, s1_luma;
  logic [3:0]    s1_tim;

  assign px   = ({8'd0, R_in} * K_R) + ({8'd0, G_in} * K_G) + ({8'd0, B_in} * K_B);
  assign luma = DW'(px >> 8);

  // Capture the pixel, its luma and the timing bits
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      s1_r <= '0; s1_g <= '0; s1_b <= '0; s1_luma <= '0; s1_tim <= '0;
    end else if (ce_pix) begin
      s1_r    <= R_in;
      s1_g    <= G_in;
      s1_b    <= B_in;
      s1_luma <= luma;
      s1_tim  <= {HSync_in, VSync_in, HBlank_in, VBlank_in};
    end
  end

  // ---------------------------------------------------------------- stage 2
  logic [DW-1:0] sel_r, sel_g, sel_b;
  logic [DW-1:0] s2_r, s2_g, s2_b;
  logic [3:0]    s2_tim;

  // Map the stage-1 pixel through the currently applied mode; unused channels 0
  always_comb begin
    sel_r = '0;
    sel_g = '0;
    sel_b = '0;
    case (mode_active)
      3'd0, 3'd1: begin sel_r = s1_r; sel_g = s1_g; sel_b = s1_b; end
      MODE_GREEN: sel_g = s1_luma;
      MODE_AMBER: begin sel_r = s1_luma; sel_g = s1_luma - (s1_luma >> 2); end
      MODE_CYAN:  begin sel_g = s1_luma; sel_b = s1_luma; end
      MODE_GRAY:  begin sel_r = s1_luma; sel_g = s1_luma; sel_b = s1_luma; end
      MODE_INV:   begin sel_r = ~s1_r; sel_g = ~s1_g; sel_b = ~s1_b; end
      default:    ;
    endcase
  end

  // Register the mode-mapped pixel and carry timing along
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      s2_r <= '0; s2_g <= '0; s2_b <= '0; s2_tim <= '0;
    end else if (ce_pix) begin
      s2_r   <= sel_r;
      s2_g   <= sel_g;
      s2_b   <= sel_b;
      s2_tim <= s1_tim;
    end
  end

  // ---------------------------------------------------------------- stage 3
  logic [DW-1:0] fin_r, fin_g, fin_b;

`ifdef COLOR_MIX_FADE_EN
  localparam int              LVL_W    = FADE_LOG2 + 1;
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(1 << FADE_LOG2);
  localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FADE_OUT = 2'd1;
  localparam logic [1:0] FADE_IN  = 2'd2;

  logic [1:0]       state, next_state;
  logic [LVL_W-1:0] lvl, next_lvl, lvl_inc;
  logic [2:0]       next_mode;
  logic             go_down;
  logic [DW+LVL_W-1:0] prod_r, prod_g, prod_b;

  assign lvl_inc = lvl + LVL_ONE;

  // Fade state, brightness level and applied mode move together on frame ticks
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      lvl         <= LVL_FULL;
      mode_active <= 3'd0;
    end else begin
      state       <= next_state;
      lvl         <= next_lvl;
      mode_active <= next_mode;
    end
  end

  // Next fade step: stepping down to 0 swaps in the latest request and turns round
  always_comb begin
    next_state = state;
    next_lvl   = lvl;
    next_mode  = mode_active;
    go_down    = 1'b0;
    if (frame_tick) begin
      case (state)
        IDLE:     go_down = (mix != mode_active);
        FADE_OUT: go_down = 1'b1;
        FADE_IN: begin
          if (mix != mode_active) begin
            go_down = 1'b1;
          end else begin
            next_lvl = lvl_inc;
            if (lvl_inc == LVL_FULL) next_state = IDLE;
          end
        end
        default:  next_state = IDLE;
      endcase
      if (go_down) begin
        if (lvl <= LVL_ONE) begin
          next_lvl   = '0;
          next_mode  = mix;
          next_state = FADE_IN;
        end else begin
          next_lvl   = lvl - LVL_ONE;
          next_state = FADE_OUT;
        end
      end
    end
  end

  // Busy for the whole fade-out / fade-in excursion
  always_comb begin
    busy = (state != IDLE);
  end

  assign prod_r = {{LVL_W{1'b0}}, s2_r} * {{DW{1'b0}}, lvl};
  assign prod_g = {{LVL_W{1'b0}}, s2_g} * {{DW{1'b0}}, lvl};
  assign prod_b = {{LVL_W{1'b0}}, s2_b} * {{DW{1'b0}}, lvl};
  assign fin_r  = DW'(prod_r >> FADE_LOG2);
  assign fin_g  = DW'(prod_g >> FADE_LOG2);
  assign fin_b  = DW'(prod_b >> FADE_LOG2);
`else
  // Without fading the new mode takes effect on the very frame tick it is seen
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n)                                mode_active <= 3'd0;
    else if (frame_tick && (mix != mode_active)) mode_active <= mix;
  end

  assign busy  = 1'b0;
  assign fin_r = s2_r;
  assign fin_g = s2_g;
  assign fin_b = s2_b;
`endif

  // Final output register keeps latency at three pixel enables in both builds
  always_ff @(posedge clk_vid or negedge reset_n) begin
    if (!reset_n) begin
      R_out <= '0; G_out <= '0; B_out <= '0;
      HSync_out <= 1'b0; VSync_out <= 1'b0; HBlank_out <= 1'b0; VBlank_out <= 1'b0;
    end else if (ce_pix) begin
      R_out <= fin_r;
      G_out <= fin_g;
      B_out <= fin_b;
      {HSync_out, VSync_out, HBlank_out, VBlank_out} <= s2_tim;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_color_mix_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_color_mix_pipe                                          |
// | Description : Self-checking bench for color_mix_pipe against a           |
// |               behavioural model (honours COLOR_MIX_FADE_EN).             |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_color_mix_pipe;

  localparam int DW        = 8;
  localparam int FADE_LOG2 = 3;
  localparam int FULL      = 1 << FADE_LOG2;
  localparam int MAXV      = (1 << DW) - 1;

  logic          clk_vid = 1'b0;
  logic          reset_n;
  logic          ce_pix;
  logic [2:0]    mix;
  logic [DW-1:0] R_in, G_in, B_in;
  logic          HSync_in, VSync_in, HBlank_in, VBlank_in;
  logic [DW-1:0] R_out, G_out, B_out;
  logic          HSync_out, VSync_out, HBlank_out, VBlank_out;
  logic [2:0]    mode_active;
  logic          busy;

  color_mix_pipe #(.DW(DW), .FADE_LOG2(FADE_LOG2)) dut (
    .clk_vid(clk_vid), .reset_n(reset_n), .ce_pix(ce_pix), .mix(mix),
    .R_in(R_in), .G_in(G_in), .B_in(B_in),
    .HSync_in(HSync_in), .VSync_in(VSync_in), .HBlank_in(HBlank_in), .VBlank_in(VBlank_in),
    .R_out(R_out), .G_out(G_out), .B_out(B_out),
    .HSync_out(HSync_out), .VSync_out(VSync_out), .HBlank_out(HBlank_out), .VBlank_out(VBlank_out),
    .mode_active(mode_active), .busy(busy)
  );

  always #5 clk_vid = ~clk_vid;

  int checks   = 0;
  int failures = 0;

  logic [3*DW+3:0] dut_vec;
  logic [3*DW+3:0] exp_vec;
  assign dut_vec = {R_out, G_out, B_out, HSync_out, VSync_out, HBlank_out, VBlank_out};

  // ------------------------------------------------------------ reference model
  // Each accepted pixel enable records the input pixel plus the mode and level in
  // force just before that edge; a pixel entering at edge e leaves after edge e+2
  // having seen the mode of edge e+1 and the level of edge e+2.
  typedef struct {
    int         r, g, b;
    logic [3:0] tim;
    int         mode;
    int         lvl;
  } hist_t;

  hist_t hist[$];
  int    m_mode, m_lvl;
  bit    m_fading, m_down, m_vb_prev;

  function automatic int luma_of(input int r, input int g, input int b);
    return (r * 54 + g * 183 + b * 18) >> 8;
  endfunction

  task automatic model_mode(input int mode, input int r, input int g, input int b,
                            output int orr, output int og, output int ob);
    int l;
    l = luma_of(r, g, b);
    orr = 0; og = 0; ob = 0;
    case (mode)
      0, 1: begin orr = r; og = g; ob = b; end
      2: og = l;
      3: begin orr = l; og = l - l / 4; end
      4: begin og = l; ob = l; end
      5: begin orr = l; og = l; ob = l; end
      6: begin orr = MAXV - r; og = MAXV - g; ob = MAXV - b; end
      default: ;
    endcase
  endtask

  task automatic model_reset();
    hist_t z;
    hist.delete();
    z.r = 0; z.g = 0; z.b = 0; z.tim = 4'b0; z.mode = 0; z.lvl = FULL;
    repeat (3) hist.push_back(z);
    m_mode = 0; m_lvl = FULL; m_fading = 0; m_down = 0; m_vb_prev = 0;
  endtask

`ifdef COLOR_MIX_FADE_EN
  task automatic fade_down(input int x);
    if (m_lvl > 0) m_lvl = m_lvl - 1;
    if (m_lvl == 0) begin m_mode = x; m_down = 0; end
    else m_down = 1;
  endtask
`endif

  task automatic model_frame(input int x);
`ifdef COLOR_MIX_FADE_EN
    if (!m_fading) begin
      if (x != m_mode) begin m_fading = 1; fade_down(x); end
    end else if (m_down || x != m_mode) begin
      fade_down(x);
    end else begin
      m_lvl = m_lvl + 1;
      if (m_lvl == FULL) m_fading = 0;
    end
`else
    if (x != m_mode) m_mode = x;
`endif
  endtask

  // One clock: advance the model alongside the DUT and form the expected outputs
  task automatic cycle();
    hist_t e;
    int er, eg, eb;
    @(posedge clk_vid);
    if (!reset_n) begin
      model_reset();
    end else if (ce_pix) begin
      e.r = int'(R_in); e.g = int'(G_in); e.b = int'(B_in);
      e.tim = {HSync_in, VSync_in, HBlank_in, VBlank_in};
      e.mode = m_mode; e.lvl = m_lvl;
      hist.push_back(e);
      if (VBlank_in && !m_vb_prev) model_frame(int'(mix));
      m_vb_prev = VBlank_in;
      hist.delete(0);
    end
    model_mode(hist[1].mode, hist[0].r, hist[0].g, hist[0].b, er, eg, eb);
`ifdef COLOR_MIX_FADE_EN
    er = (er * hist[2].lvl) >> FADE_LOG2;
    eg = (eg * hist[2].lvl) >> FADE_LOG2;
    eb = (eb * hist[2].lvl) >> FADE_LOG2;
`endif
    exp_vec = {er[DW-1:0], eg[DW-1:0], eb[DW-1:0], hist[0].tim};
    #1;
  endtask

  task automatic rand_px();
    R_in = DW'($urandom_range(0, MAXV));
    G_in = DW'($urandom_range(0, MAXV));
    B_in = DW'($urandom_range(0, MAXV));
    HSync_in = 1'($urandom_range(0, 1));
    VSync_in = 1'($urandom_range(0, 1));
    HBlank_in = 1'($urandom_range(0, 1));
  endtask

  task automatic set_px(input int r, input int g, input int b);
    R_in = DW'(r); G_in = DW'(g); B_in = DW'(b);
  endtask

  // A frame: VBlank high for its first two cycles, so one rising edge per frame
  task automatic do_frame(input int len, input bit rnd);
    for (int i = 0; i < len; i++) begin
      VBlank_in = (i < 2);
      if (rnd) rand_px();
      cycle();
    end
  endtask

  // Request a mode and run frames (bounded) until the model reports it settled
  task automatic switch_mode(input int m);
    mix = 3'(m);
    for (int n = 0; n < 40 && (m_mode != m || m_fading); n++) do_frame(6, 0);
    VBlank_in = 1'b0;
    repeat (4) cycle();
  endtask

  // ------------------------------------------------------------ tests
  task automatic test_reset();
    reset_n = 1'b0; ce_pix = 1'b1; mix = 3'd6;
    set_px(50, 60, 70);
    HSync_in = 1'b1; VSync_in = 1'b1; HBlank_in = 1'b1; VBlank_in = 1'b1;
    repeat (3) cycle();
    checks++;
    if (dut_vec !== '0) begin failures++; $display("FAIL reset_outputs: got %h want 0", dut_vec); end
    checks++;
    if (mode_active !== 3'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mode: got mode=%0d busy=%0b want 0/0", mode_active, busy);
    end
    checks++;
    if (HSync_out !== 1'b0) begin failures++; $display("FAIL reset_hsync: got %b want 0", HSync_out); end
    mix = 3'd0; set_px(0, 0, 0);
    HSync_in = 1'b0; VSync_in = 1'b0; HBlank_in = 1'b0; VBlank_in = 1'b0;
    reset_n = 1'b1;
    repeat (4) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin failures++; $display("FAIL post_reset: got %h want %h", dut_vec, exp_vec); end
    end
  endtask

  task automatic test_latency();
    set_px(10, 20, 30); HSync_in = 1'b1;
    cycle();
    HSync_in = 1'b0;
    cycle();
    checks++;
    if (R_out !== 8'd0 || HSync_out !== 1'b0) begin
      failures++; $display("FAIL latency_early: got R=%0d hs=%b want 0/0", R_out, HSync_out);
    end
    cycle();
    checks++;
    if ({R_out, G_out, B_out} !== {8'd10, 8'd20, 8'd30} || HSync_out !== 1'b1) begin
      failures++; $display("FAIL latency_3: got %0d,%0d,%0d hs=%b want 10,20,30 hs=1", R_out, G_out, B_out, HSync_out);
    end
    cycle();
    checks++;
    if (dut_vec !== exp_vec) begin failures++; $display("FAIL latency_model: got %h want %h", dut_vec, exp_vec); end
  endtask

  task automatic test_modes();
    switch_mode(5); set_px(255, 255, 255); repeat (4) cycle();
    checks++;
    if ({R_out, G_out, B_out} !== {8'd254, 8'd254, 8'd254}) begin
      failures++; $display("FAIL gray_white: got %0d,%0d,%0d want 254,254,254", R_out, G_out, B_out);
    end
    switch_mode(3); repeat (4) cycle();
    checks++;
    if ({R_out, G_out, B_out} !== {8'd254, 8'd191, 8'd0}) begin
      failures++; $display("FAIL amber_white: got %0d,%0d,%0d want 254,191,0", R_out, G_out, B_out);
    end
    switch_mode(2); set_px(100, 0, 0); repeat (4) cycle();
    checks++;
    if ({R_out, G_out, B_out} !== {8'd0, 8'd21, 8'd0}) begin
      failures++; $display("FAIL green_red100: got %0d,%0d,%0d want 0,21,0", R_out, G_out, B_out);
    end
    switch_mode(6); set_px(0, 255, 15); repeat (4) cycle();
    checks++;
    if ({R_out, G_out, B_out} !== {8'd255, 8'd0, 8'd240}) begin
      failures++; $display("FAIL inverted: got %0d,%0d,%0d want 255,0,240", R_out, G_out, B_out);
    end
    for (int m = 0; m < 8; m++) begin
      switch_mode(m);
      for (int i = 0; i < 20; i++) begin
        rand_px(); cycle();
        checks++;
        if (dut_vec !== exp_vec) begin
          failures++; $display("FAIL mode%0d_random: got %h want %h", m, dut_vec, exp_vec);
        end
      end
    end
  endtask

  task automatic test_mix_between_ticks();
    switch_mode(0);
    mix = 3'd4;
    repeat (3) cycle();
    checks++;
    if (mode_active !== 3'd0) begin failures++; $display("FAIL mix_no_tick: got %0d want 0", mode_active); end
    VBlank_in = 1'b1;
    cycle();
    checks++;
`ifdef COLOR_MIX_FADE_EN
    if (mode_active !== 3'd0 || busy !== 1'b1) begin
      failures++; $display("FAIL first_tick: got mode=%0d busy=%b want 0/1", mode_active, busy);
    end
`else
    if (mode_active !== 3'd4 || busy !== 1'b0) begin
      failures++; $display("FAIL first_tick: got mode=%0d busy=%b want 4/0", mode_active, busy);
    end
`endif
    VBlank_in = 1'b0;
    switch_mode(4);
  endtask

`ifdef COLOR_MIX_FADE_EN
  task automatic test_fade();
    switch_mode(0); set_px(200, 200, 200); mix = 3'd5;
    for (int k = 1; k <= FULL; k++) begin
      do_frame(8, 0);
      checks++;
      if (dut_vec !== exp_vec) begin failures++; $display("FAIL fade_out_%0d: got %h want %h", k, dut_vec, exp_vec); end
      if (k == FULL / 2) begin
        checks++;
        if (R_out !== 8'd100) begin failures++; $display("FAIL fade_half: got %0d want 100", R_out); end
      end
    end
    checks++;
    if (mode_active !== 3'd5 || busy !== 1'b1) begin
      failures++; $display("FAIL fade_bottom: got mode=%0d busy=%b want 5/1", mode_active, busy);
    end
    for (int k = 1; k <= FULL; k++) begin
      do_frame(8, 0);
      checks++;
      if (busy !== (k < FULL)) begin failures++; $display("FAIL fade_in_busy_%0d: got %b", k, busy); end
    end
  endtask

  task automatic test_fade_abort();
    mix = 3'd0;
    repeat (FULL + 3) do_frame(8, 0);
    mix = 3'd2;
    do_frame(8, 0);
    checks++;
    if (R_out !== 8'd50 || busy !== 1'b1) begin
      failures++; $display("FAIL abort_lvl2: got R=%0d busy=%b want 50/1", R_out, busy);
    end
    do_frame(8, 0);
    checks++;
    if (R_out !== 8'd25) begin failures++; $display("FAIL abort_lvl1: got %0d want 25", R_out); end
    do_frame(8, 0);
    checks++;
    if (mode_active !== 3'd2) begin failures++; $display("FAIL abort_mode: got %0d want 2", mode_active); end
    repeat (FULL) do_frame(8, 0);
    checks++;
    if (busy !== 1'b0 || {R_out, G_out, B_out} !== {8'd0, 8'd199, 8'd0}) begin
      failures++; $display("FAIL abort_done: got busy=%b %0d,%0d,%0d want 0 0,199,0", busy, R_out, G_out, B_out);
    end
  endtask
`endif

  task automatic test_ce_hold();
    logic [3*DW+3:0] held;
    mix = (m_mode == 5) ? 3'd1 : 3'd5;
    do_frame(6, 1);
    VBlank_in = 1'b0;
    repeat (3) begin rand_px(); cycle(); end
    held = exp_vec;
    ce_pix = 1'b0;
    for (int i = 0; i < 5; i++) begin
      rand_px(); VBlank_in = (i >= 2);
      cycle();
      checks++;
      if (dut_vec !== held || mode_active !== m_mode[2:0] || busy !== m_fading) begin
        failures++; $display("FAIL ce_hold_%0d: got %h mode=%0d busy=%b want %h mode=%0d busy=%b",
                             i, dut_vec, mode_active, busy, held, m_mode, m_fading);
      end
    end
    ce_pix = 1'b1;
    repeat (4) begin
      cycle();
      checks++;
      if (dut_vec !== exp_vec || mode_active !== m_mode[2:0] || busy !== m_fading) begin
        failures++; $display("FAIL ce_resume: got %h mode=%0d want %h mode=%0d", dut_vec, mode_active, exp_vec, m_mode);
      end
    end
    VBlank_in = 1'b0;
  endtask

  task automatic test_reset_mid_fade();
    mix = (m_mode == 6) ? 3'd7 : 3'd6;
    repeat (3) do_frame(6, 1);
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dut_vec !== '0 || mode_active !== 3'd0 || busy !== 1'b0) begin
      failures++; $display("FAIL reset_mid_fade: got %h mode=%0d busy=%b want 0", dut_vec, mode_active, busy);
    end
    model_reset();
    mix = 3'd0; VBlank_in = 1'b0;
    cycle();
    reset_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    int flen, pos;
    flen = 6; pos = 0;
    for (int i = 0; i < 800; i++) begin
      if (pos == 0) begin
        flen = $urandom_range(6, 12);
        if ($urandom_range(0, 2) != 0) mix = 3'($urandom_range(0, 7));
      end
      VBlank_in = (pos < 2);
      ce_pix = ($urandom_range(0, 4) != 0);
      rand_px();
      cycle();
      checks++;
      if (dut_vec !== exp_vec) begin failures++; $display("FAIL b2b_pixel@%0d: got %h want %h", i, dut_vec, exp_vec); end
      checks++;
      if (mode_active !== m_mode[2:0] || busy !== m_fading) begin
        failures++; $display("FAIL b2b_state@%0d: got mode=%0d busy=%b want %0d/%b", i, mode_active, busy, m_mode, m_fading);
      end
      pos = (pos + 1 == flen) ? 0 : pos + 1;
    end
    ce_pix = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; ce_pix = 1'b1; mix = 3'd0;
    set_px(0, 0, 0);
    HSync_in = 1'b0; VSync_in = 1'b0; HBlank_in = 1'b0; VBlank_in = 1'b0;
    model_reset();
    exp_vec = '0;
    test_reset();
    test_latency();
    test_modes();
    test_mix_between_ticks();
`ifdef COLOR_MIX_FADE_EN
    test_fade();
    test_fade_abort();
`endif
    test_ce_hold();
    test_reset_mid_fade();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
